// File: rtl/aes_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the AES decipher engine.
// Multiplications reduce modulo x^8+x^4+x^3+x+1 (0x11B).
package aes_pkg;

    localparam int AES128_ROUNDS = 10;
    localparam int AES256_ROUNDS = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        MAIN  = 2'd2,
        FINAL = 2'd3
    } aes_fsm_e;

    function automatic logic [7:0] gm2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm09(input logic [7:0] x);
        return gm2(gm2(gm2(x))) ^ x;
    endfunction

    function automatic logic [7:0] gm11(input logic [7:0] x);
        return gm2(gm2(gm2(x))) ^ gm2(x) ^ x;
    endfunction

    function automatic logic [7:0] gm13(input logic [7:0] x);
        return gm2(gm2(gm2(x))) ^ gm2(gm2(x)) ^ x;
    endfunction

    function automatic logic [7:0] gm14(input logic [7:0] x);
        return gm2(gm2(gm2(x))) ^ gm2(gm2(x)) ^ gm2(x);
    endfunction

endpackage

// File: rtl/aes_inv_mixw.sv
// Inverse MixColumn on one 32-bit column; row 0 is the most significant byte.
module aes_inv_mixw
    import aes_pkg::*;
(
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);

    logic [7:0] w_a0, w_a1, w_a2, w_a3;

    assign w_a0 = i_col[31:24];
    assign w_a1 = i_col[23:16];
    assign w_a2 = i_col[15:8];
    assign w_a3 = i_col[7:0];

    assign o_col = {gm14(w_a0) ^ gm11(w_a1) ^ gm13(w_a2) ^ gm09(w_a3),
                    gm09(w_a0) ^ gm14(w_a1) ^ gm11(w_a2) ^ gm13(w_a3),
                    gm13(w_a0) ^ gm09(w_a1) ^ gm14(w_a2) ^ gm11(w_a3),
                    gm11(w_a0) ^ gm13(w_a1) ^ gm09(w_a2) ^ gm14(w_a3)};

endmodule

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box: inverse affine transform followed by the GF(2^8) multiplicative inverse.
// Expressed arithmetically; it reduces to the usual 8-in/8-out lookup function.
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_x,
    output logic [7:0] o_y
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = gm2(t);
        end
        return p;
    endfunction

    // x^254 == x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] t;
        r = 8'h01;
        t = x;
        for (int i = 0; i < 7; i++) begin
            t = gf_mul(t, t);
            r = gf_mul(r, t);
        end
        return r;
    endfunction

    logic [7:0] w_aff;

    assign w_aff = {i_x[6:0], i_x[7]} ^ {i_x[4:0], i_x[7:5]} ^ {i_x[1:0], i_x[7:2]} ^ 8'h05;
    assign o_y   = gf_inv(w_aff);

endmodule

// File: rtl/aes_decipher_block_iter.sv
// Iterative AES-128/256 block decipher, one inverse round per clock.
// Round keys come from an external key memory addressed by 'round' in the same cycle.
module aes_decipher_block_iter
    import aes_pkg::*;
#(
    parameter bit AES256_EN = 1'b1,
    parameter bit OUT_REG   = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    input  logic [127:0] block,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [127:0] new_block,
    output logic         ready,
    output logic         valid
);

    aes_fsm_e     r_fsm;
    logic [127:0] r_state;
    logic [3:0]   r_round;
    logic         r_ready;
    logic         r_valid;

    logic [3:0]   w_nr;
    logic [127:0] w_isb;
    logic [127:0] w_ark;
    logic [127:0] w_mix;

    assign w_nr = (AES256_EN && keylen) ? 4'(AES256_ROUNDS) : 4'(AES128_ROUNDS);

    // Byte k sits at row k%4, column k/4; InvShiftRows rotates row r right by r.
    for (genvar k = 0; k < 16; k++) begin : g_byte
        localparam int ROW = k % 4;
        localparam int COL = k / 4;
        localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;

        aes_inv_sbox u_sbox (
            .i_x (r_state[127-8*SRC -: 8]),
            .o_y (w_isb[127-8*k -: 8])
        );
    end

    assign w_ark = w_isb ^ round_key;

    for (genvar c = 0; c < 4; c++) begin : g_col
        aes_inv_mixw u_mixw (
            .i_col (w_ark[127-32*c -: 32]),
            .o_col (w_mix[127-32*c -: 32])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fsm   <= IDLE;
            r_state <= '0;
            r_round <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (next) begin
                        r_state <= block;
                        r_round <= w_nr;
                        r_ready <= 1'b0;
                        r_valid <= 1'b0;
                        r_fsm   <= INIT;
                    end
                end
                INIT: begin
                    r_state <= r_state ^ round_key;
                    r_round <= r_round - 4'd1;
                    r_fsm   <= MAIN;
                end
                MAIN: begin
                    r_state <= w_mix;
                    if (r_round == 4'd1) begin
                        r_round <= 4'd0;
                        r_fsm   <= FINAL;
                    end else begin
                        r_round <= r_round - 4'd1;
                    end
                end
                FINAL: begin
                    // Last round skips InvMixColumns.
                    r_state <= w_ark;
                    r_ready <= 1'b1;
                    r_valid <= 1'b1;
                    r_fsm   <= IDLE;
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    if (OUT_REG) begin : g_out_reg
        logic [127:0] r_out;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_out <= '0;
            end else if (r_fsm == FINAL) begin
                r_out <= w_ark;
            end
        end

        assign new_block = r_out;
    end else begin : g_out_state
        assign new_block = r_state;
    end

    assign round = r_round;
    assign ready = r_ready;
    assign valid = r_valid;

endmodule

// File: tb/tb_aes_decipher_block_iter.sv
// Directed bench: FIPS-197 vectors, back-to-back, busy-next, mid-run reset and AES-128-only build.
module tb_aes_decipher_block_iter;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;

    logic         next0 = 1'b0, keylen0 = 1'b0, key_sel0 = 1'b0;
    logic [127:0] block0 = '0;
    logic [3:0]   round0;
    logic [127:0] round_key0, new_block0;
    logic         ready0, valid0;

    logic         next1 = 1'b0, keylen1 = 1'b0;
    logic [127:0] block1 = '0;
    logic [3:0]   round1;
    logic [127:0] round_key1, new_block1;
    logic         ready1, valid1;

    logic [127:0] rk128 [0:10];
    logic [127:0] rk256 [0:14];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   rseq[$];
    logic c0_ready, c0_valid;

    aes_decipher_block_iter #(.AES256_EN(1'b1), .OUT_REG(1'b1)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .next(next0), .keylen(keylen0), .block(block0),
        .round(round0), .round_key(round_key0), .new_block(new_block0),
        .ready(ready0), .valid(valid0)
    );

    aes_decipher_block_iter #(.AES256_EN(1'b0), .OUT_REG(1'b0)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .next(next1), .keylen(keylen1), .block(block1),
        .round(round1), .round_key(round_key1), .new_block(new_block1),
        .ready(ready1), .valid(valid1)
    );

    always #5 clk = ~clk;

    // Key memory model: combinational lookup of the expanded schedule.
    always_comb begin
        round_key0 = '0;
        if (key_sel0) begin
            if (round0 <= 4'd14) round_key0 = rk256[round0];
        end else if (round0 <= 4'd10) begin
            round_key0 = rk128[round0];
        end
    end

    always_comb begin
        round_key1 = '0;
        if (round1 <= 4'd10) round_key1 = rk128[round1];
    end

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] fmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xt(t);
        end
        return p;
    endfunction

    function automatic logic [7:0] fsbox(input logic [7:0] x);
        logic [7:0] inv, t;
        inv = 8'h01;
        t = x;
        for (int i = 0; i < 7; i++) begin
            t = fmul(t, t);
            inv = fmul(inv, t);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {fsbox(w[31:24]), fsbox(w[23:16]), fsbox(w[15:8]), fsbox(w[7:0])};
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nk);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            if (nk == 4) rk128[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk256[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    // Stimulus driver: the first edge accepts the start; cyc counts edges after it until valid.
    task automatic run_dut(input bit d, input int disturb_at, input int next_from, output int cyc);
        cyc = 0;
        rseq.delete();
        @(posedge clk); #1;
        if (d) next1 = 1'b0; else next0 = 1'b0;
        c0_ready = d ? ready1 : ready0;
        c0_valid = d ? valid1 : valid0;
        rseq.push_back(d ? int'(round1) : int'(round0));
        while (cyc < 40) begin
            if (disturb_at >= 0 && cyc == disturb_at) begin
                next0 = 1'b1;
                block0 = ~block0;
                keylen0 = ~keylen0;
            end else if (disturb_at >= 0 && cyc == disturb_at + 1) begin
                next0 = 1'b0;
            end
            if (next_from >= 0 && cyc == next_from) next0 = 1'b1;
            @(posedge clk); #1;
            cyc++;
            rseq.push_back(d ? int'(round1) : int'(round0));
            if ((d ? valid1 : valid0) === 1'b1) break;
        end
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        n_cmp++; if (ready0 !== 1'b1) begin n_bad++; $display("FAIL reset_ready0: got %b expected 1", ready0); end
        n_cmp++; if (valid0 !== 1'b0) begin n_bad++; $display("FAIL reset_valid0: got %b expected 0", valid0); end
        n_cmp++; if (new_block0 !== 128'h0) begin n_bad++; $display("FAIL reset_block0: got %h expected 0", new_block0); end
        n_cmp++; if (round0 !== 4'd0) begin n_bad++; $display("FAIL reset_round0: got %0d expected 0", round0); end
        n_cmp++; if (ready1 !== 1'b1 || valid1 !== 1'b0 || new_block1 !== 128'h0)
            begin n_bad++; $display("FAIL reset_dut1: got ready=%b valid=%b blk=%h expected 1/0/0", ready1, valid1, new_block1); end
    endtask

    task automatic test_aes128;
        int cyc;
        bit bad;
        @(negedge clk);
        block0 = C128; keylen0 = 1'b0; key_sel0 = 1'b0; next0 = 1'b1;
        run_dut(1'b0, -1, -1, cyc);
        n_cmp++; if (c0_ready !== 1'b0 || c0_valid !== 1'b0)
            begin n_bad++; $display("FAIL aes128_start_flags: got ready=%b valid=%b expected 0/0", c0_ready, c0_valid); end
        n_cmp++; if (cyc !== 11) begin n_bad++; $display("FAIL aes128_latency: got %0d expected 11", cyc); end
        n_cmp++; if (new_block0 !== PT) begin n_bad++; $display("FAIL aes128_result: got %h expected %h", new_block0, PT); end
        n_cmp++; if (ready0 !== 1'b1) begin n_bad++; $display("FAIL aes128_ready: got %b expected 1", ready0); end
        bad = (rseq.size() != 12);
        for (int i = 0; i < rseq.size(); i++) if (rseq[i] != ((10 - i) > 0 ? 10 - i : 0)) bad = 1'b1;
        n_cmp++; if (bad) begin n_bad++; $display("FAIL aes128_round_seq: got %p expected 10 down to 0", rseq); end
        @(posedge clk); #1;
        n_cmp++; if (valid0 !== 1'b1 || new_block0 !== PT)
            begin n_bad++; $display("FAIL aes128_hold: got valid=%b blk=%h expected 1/%h", valid0, new_block0, PT); end
    endtask

    task automatic test_aes256;
        int cyc;
        bit bad;
        @(negedge clk);
        block0 = C256; keylen0 = 1'b1; key_sel0 = 1'b1; next0 = 1'b1;
        run_dut(1'b0, -1, -1, cyc);
        n_cmp++; if (cyc !== 15) begin n_bad++; $display("FAIL aes256_latency: got %0d expected 15", cyc); end
        n_cmp++; if (new_block0 !== PT) begin n_bad++; $display("FAIL aes256_result: got %h expected %h", new_block0, PT); end
        bad = (rseq.size() != 16);
        for (int i = 0; i < rseq.size(); i++) if (rseq[i] != ((14 - i) > 0 ? 14 - i : 0)) bad = 1'b1;
        n_cmp++; if (bad) begin n_bad++; $display("FAIL aes256_round_seq: got %p expected 14 down to 0", rseq); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        @(negedge clk);
        block0 = C128; keylen0 = 1'b0; key_sel0 = 1'b0; next0 = 1'b1;
        run_dut(1'b0, -1, 10, cyc);
        // next was high across the completing edge: must not have restarted
        n_cmp++; if (cyc !== 11 || valid0 !== 1'b1 || ready0 !== 1'b1 || new_block0 !== PT)
            begin n_bad++; $display("FAIL b2b_first: got cyc=%0d valid=%b ready=%b blk=%h expected 11/1/1/%h",
                                    cyc, valid0, ready0, new_block0, PT); end
        block0 = C256; keylen0 = 1'b1; key_sel0 = 1'b1;
        run_dut(1'b0, -1, -1, cyc);
        n_cmp++; if (c0_valid !== 1'b0 || c0_ready !== 1'b0 || rseq[0] != 14)
            begin n_bad++; $display("FAIL b2b_accept: got valid=%b ready=%b round=%0d expected 0/0/14", c0_valid, c0_ready, rseq[0]); end
        n_cmp++; if (cyc !== 15 || new_block0 !== PT)
            begin n_bad++; $display("FAIL b2b_second: got cyc=%0d blk=%h expected 15/%h", cyc, new_block0, PT); end
    endtask

    task automatic test_busy_next;
        int cyc;
        @(negedge clk);
        block0 = C128; keylen0 = 1'b0; key_sel0 = 1'b0; next0 = 1'b1;
        run_dut(1'b0, 3, -1, cyc);
        n_cmp++; if (cyc !== 11) begin n_bad++; $display("FAIL busy_latency: got %0d expected 11", cyc); end
        n_cmp++; if (new_block0 !== PT) begin n_bad++; $display("FAIL busy_result: got %h expected %h", new_block0, PT); end
    endtask

    task automatic test_reset_midop;
        int cyc;
        @(negedge clk);
        block0 = C128; keylen0 = 1'b0; key_sel0 = 1'b0; next0 = 1'b1;
        @(posedge clk); #1;
        next0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (round0 !== 4'd5) begin n_bad++; $display("FAIL midrst_round_before: got %0d expected 5", round0); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (ready0 !== 1'b1 || valid0 !== 1'b0)
            begin n_bad++; $display("FAIL midrst_flags: got ready=%b valid=%b expected 1/0", ready0, valid0); end
        n_cmp++; if (new_block0 !== 128'h0 || round0 !== 4'd0)
            begin n_bad++; $display("FAIL midrst_clear: got blk=%h round=%0d expected 0/0", new_block0, round0); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        next0 = 1'b1;
        run_dut(1'b0, -1, -1, cyc);
        n_cmp++; if (cyc !== 11 || new_block0 !== PT)
            begin n_bad++; $display("FAIL midrst_rerun: got cyc=%0d blk=%h expected 11/%h", cyc, new_block0, PT); end
    endtask

    task automatic test_aes256_disabled;
        int cyc;
        @(negedge clk);
        block1 = C128; keylen1 = 1'b1; next1 = 1'b1;
        run_dut(1'b1, -1, -1, cyc);
        n_cmp++; if (rseq[0] != 10) begin n_bad++; $display("FAIL no256_first_round: got %0d expected 10", rseq[0]); end
        n_cmp++; if (cyc !== 11) begin n_bad++; $display("FAIL no256_latency: got %0d expected 11", cyc); end
        n_cmp++; if (new_block1 !== PT) begin n_bad++; $display("FAIL no256_result: got %h expected %h", new_block1, PT); end
    endtask

    initial begin
        expand_key({K128, 128'h0}, 4);
        expand_key(K256, 8);
        repeat (2) @(posedge clk);
        test_reset;
        @(negedge clk);
        reset_n = 1'b1;
        test_aes128;
        test_aes256;
        test_back_to_back;
        test_busy_next;
        test_reset_midop;
        test_aes256_disabled;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
